apb_reg_bank: RTL

- Parametrised APB slave front-end for timer-class peripherals.
- Decodes paddr into NUM_REGS register slots and generates programmable wait states. Drives registered prdata, pready and pslverr.
- Issues per-register write-enable and read-strobe pulses, e.g. for TDR/TCR writes and clear-on-read of TSR flags.
- Sits between the APB interconnect and the peripheral's register storage. It replaces the fixed three-register read mux.

---
 rtl/apb_reg_bank.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/apb_reg_bank.sv
// APB slave front-end for timer-class peripherals: decodes the word index into
// register slots, inserts programmable wait states and pulses per-slot strobes.
module apb_reg_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK = NUM_REGS'(4'b0100)
) (
  input  logic pclk,
  input  logic presetn,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic pready,
  output logic pslverr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_rdata,
  output logic [NUM_REGS-1:0] reg_wr_en,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [NUM_REGS-1:0] reg_rd_stb
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic setup, go_done;

  logic hit, ro;
  logic [NUM_REGS-1:0] sel;
  logic [DATA_WIDTH-1:0] slot;

  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic pready_q, pready_d;
  logic pslverr_q, pslverr_d;
  logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_REGS-1:0] rd_stb_q, rd_stb_d;

  always_comb begin
    setup   = psel & ~penable;
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdat_d  = wdat_q;
    go_done = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (setup) begin
          addr_d = paddr;
          wr_d   = pwrite;
          wdat_d = pwdata;
          cnt_d  = WS;
          if (WS == 4'd0) begin
            state_d = S_DONE;
            go_done = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!psel) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (penable && cnt_q == 4'd1) begin
          state_d = S_DONE;
          go_done = 1'b1;
          cnt_d   = 4'd0;
        end else if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decode uses the address that will be latched at this edge, so a
  // zero-wait transfer sees paddr straight from the setup phase.
  always_comb begin
    sel  = '0;
    slot = '0;
    hit  = 1'b0;
    ro   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_d == ADDR_WIDTH'(i)) begin
        sel[i] = 1'b1;
        hit    = 1'b1;
        ro     = RO_MASK[i];
        slot   = reg_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    wr_en_d   = '0;
    wdata_d   = '0;
    rd_stb_d  = '0;
    if (go_done) begin
      pready_d = 1'b1;
      if (wr_d) begin
        if (hit && !ro) begin
          wr_en_d = sel;
          wdata_d = wdat_d;
        end else begin
          pslverr_d = 1'b1;
        end
      end else if (hit) begin
        prdata_d = slot;
        rd_stb_d = sel;
      end else begin
        pslverr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdat_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      wr_en_q   <= '0;
      wdata_q   <= '0;
      rd_stb_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdat_q    <= wdat_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      wr_en_q   <= wr_en_d;
      wdata_q   <= wdata_d;
      rd_stb_q  <= rd_stb_d;
    end
  end

  assign prdata     = prdata_q;
  assign pready     = pready_q;
  assign pslverr    = pslverr_q;
  assign reg_wr_en  = wr_en_q;
  assign reg_wdata  = wdata_q;
  assign reg_rd_stb = rd_stb_q;

endmodule
